draw_arbiter: RTL and testbench
===============================

DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 The block SHALL have parameter SIZE, default 4, giving the sprite box edge in pixels (legal range 1..16).
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  3  per-requester draw/erase request; bit i belongs to requester i.
REQ-005 req_x  input  24  requester i base X in bits [8i+7:8i].
REQ-006 req_y  input  21  requester i base Y in bits [7i+6:7i].
REQ-007 req_colour  input  9  requester i colour in bits [3i+2:3i]; erase is colour 3'b000.
REQ-008 grant  output  3  one-hot owner of the VGA write port, or all zero.
REQ-009 done  output  3  one-cycle pulse to the owner when its box is complete.
REQ-010 vga_x  output  8  pixel X to the VGA adapter.
REQ-011 vga_y  output  7  pixel Y to the VGA adapter.
REQ-012 vga_colour  output  3  pixel colour to the VGA adapter.
REQ-013 plot  output  1  write-enable to the VGA adapter.
REQ-014 busy  output  1  high in any state other than S_IDLE.

Function
REQ-015 States SHALL be S_IDLE, S_PLOT and S_DONE.
REQ-016 In S_IDLE with req nonzero, the block SHALL select one requester round-robin, searching from (last_grant+1) mod 3 upward.
REQ-017 In the same cycle as REQ-016 it SHALL latch that requester's x, y and colour, set grant one-hot, clear cx/cy, and enter S_PLOT.
REQ-018 In S_IDLE with req zero, the block SHALL stay in S_IDLE, with grant, plot and done at 0.
REQ-019 In S_PLOT, plot SHALL be 1 and each cycle SHALL emit vga_x = base_x + cx (mod 256), vga_y = base_y + cy (mod 128), and vga_colour = the latched colour.
REQ-020 Counter cx SHALL step 0..SIZE-1; at SIZE-1 it SHALL wrap to 0 and cy SHALL increment.
REQ-021 When cx = cy = SIZE-1, the block SHALL emit that final pixel and enter S_DONE; S_PLOT therefore lasts exactly SIZE*SIZE cycles.
REQ-022 In S_DONE, done[owner] SHALL be 1 for one cycle and plot SHALL be 0.
REQ-023 In S_DONE, last_grant SHALL take the owner's index, grant SHALL clear at the exit edge, and the next state SHALL be S_IDLE.
REQ-024 Latency: with req set in S_IDLE at cycle 0, plot SHALL be high for cycles 1..SIZE*SIZE, done SHALL pulse at cycle SIZE*SIZE+1, and the earliest next grant SHALL be at cycle SIZE*SIZE+2.
REQ-025 req and req_x/y/colour SHALL be sampled only at the S_IDLE grant edge; any change, including deassertion, during S_PLOT/S_DONE SHALL be ignored, and the box SHALL complete.
REQ-026 A requester SHALL hold req until it sees its done pulse; req still high in S_IDLE after done SHALL be treated as a new request.
REQ-027 Coordinate overflow SHALL wrap silently; no clipping and no error flag.
REQ-028 With SIZE=1, S_PLOT SHALL last one cycle.
REQ-029 Outside S_PLOT, vga_x, vga_y and vga_colour SHALL hold their last values; only plot qualifies them.

Reset
REQ-030 While reset is high at a clock edge, the block SHALL enter S_IDLE.
REQ-031 On that edge it SHALL set grant=0, done=0, plot=0, vga_x=0, vga_y=0, vga_colour=0, cx=cy=0, and last_grant=2, so requester 0 has first priority.
REQ-032 Reset asserted mid-S_PLOT SHALL abort the box with no done pulse; reset has priority over every other event.

Verification
REQ-033 SIZE=4, req=001, x0=10, y0=20, colour0=3'b100 -> 16 plot cycles covering (10..13, 20..23) in row-major order, then done=001 for one cycle, then busy=0.
REQ-034 req=111 held, each requester dropping its bit after its own done -> grants in order 001, 010, 100, each box 16 plot cycles, with exactly 1 idle cycle between boxes.
REQ-035 req1 and req2 held continuously after a grant to requester 1 -> next grant 100, then 010 (round-robin, no starvation).
REQ-036 x0=254, y0=126, SIZE=4 -> vga_x sequence 254, 255, 0, 1 and vga_y 126, 127, 0, 1.
REQ-037 req0 dropped at plot cycle 5 -> all 16 pixels still emitted and done pulses.
REQ-038 reset at plot cycle 7 -> next cycle plot=0 and grant=0, no done pulse; a following req0 restarts at cx=cy=0.

Source files
------------

// File: rtl/draw_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : draw_arbiter_if
//  Description : Bundle of the draw requester bus and the VGA write port that
//                connect three sprite requesters to the draw arbiter.
//                  req        [2:0]   per-requester draw/erase request
//                  req_x      [23:0]  requester i base X in [8i+7:8i]
//                  req_y      [20:0]  requester i base Y in [7i+6:7i]
//                  req_colour [8:0]   requester i colour in [3i+2:3i]
//                  grant      [2:0]   one-hot owner of the VGA port
//                  done       [2:0]   one-cycle completion pulse to owner
//                  vga_x/vga_y/vga_colour/plot  VGA adapter write port
//                  busy               arbiter not idle
//                master : requester side (drives req*)
//                slave  : arbiter side (drives grant/done/vga*/plot/busy)
//  Revision    : 1.0  initial release
// ============================================================================
interface draw_arbiter_if;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_colour;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot;
  logic        busy;

  modport master (
    output req, req_x, req_y, req_colour,
    input  grant, done, vga_x, vga_y, vga_colour, plot, busy
  );

  modport slave (
    input  req, req_x, req_y, req_colour,
    output grant, done, vga_x, vga_y, vga_colour, plot, busy
  );
endinterface
`default_nettype wire

// File: rtl/draw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : draw_arbiter
//  Description : Round-robin arbiter that grants one of three requesters the
//                VGA write port and plots a SIZE x SIZE box for it, one pixel
//                per cycle in row-major order, then pulses done to the owner.
//  Ports       : clk    system clock (rising edge)
//                reset  synchronous active-high reset
//                bus    draw_arbiter_if.slave (requests in, VGA port out)
//  Parameters  : SIZE   box edge in pixels, 1..16
//  Revision    : 1.0  initial release
// ============================================================================
module draw_arbiter #(
  parameter int SIZE = 4
) (
  input  logic               clk,
  input  logic               reset,
  draw_arbiter_if.slave      bus
);

  // Counter width; at least one bit so SIZE=1 still has a legal vector.
  localparam int              CW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0]   C_LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLOT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [1:0]    last_grant_q, last_grant_d;
  logic [7:0]    base_x_q, base_x_d;
  logic [6:0]    base_y_q, base_y_d;
  logic [2:0]    colour_q, colour_d;
  logic [CW-1:0] cx_q, cx_d;
  logic [CW-1:0] cy_q, cy_d;

  // Round-robin selection result
  logic          sel_valid;
  logic [1:0]    sel_idx;
  logic [1:0]    cand;
  logic [7:0]    sel_x;
  logic [6:0]    sel_y;
  logic [2:0]    sel_colour;

  // --------------------------------------------------------------------------
  // Round-robin pick: search starts one past the previous owner and wraps
  // modulo 3, so the most recently served requester has lowest priority.
  // --------------------------------------------------------------------------
  always_comb begin : p_select
    sel_valid = 1'b0;
    sel_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      cand = 2'((int'(last_grant_q) + k) % 3);
      if (!sel_valid && bus.req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin : p_operand_mux
    sel_x      = bus.req_x[7:0];
    sel_y      = bus.req_y[6:0];
    sel_colour = bus.req_colour[2:0];
    case (sel_idx)
      2'd1: begin
        sel_x      = bus.req_x[15:8];
        sel_y      = bus.req_y[13:7];
        sel_colour = bus.req_colour[5:3];
      end
      2'd2: begin
        sel_x      = bus.req_x[23:16];
        sel_y      = bus.req_y[20:14];
        sel_colour = bus.req_colour[8:6];
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Request inputs are only looked at in S_IDLE; once a box
  // starts it runs to completion regardless of what the requesters do.
  // On the final pixel the counters are left at SIZE-1 so the VGA outputs
  // keep presenting the last plotted pixel until the next box starts.
  // --------------------------------------------------------------------------
  always_comb begin : p_next
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    base_x_d     = base_x_q;
    base_y_d     = base_y_q;
    colour_d     = colour_q;
    cx_d         = cx_q;
    cy_d         = cy_q;

    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          grant_d  = 3'b001 << sel_idx;
          base_x_d = sel_x;
          base_y_d = sel_y;
          colour_d = sel_colour;
          cx_d     = '0;
          cy_d     = '0;
          state_d  = S_PLOT;
        end
      end

      S_PLOT: begin
        if (cx_q == C_LAST) begin
          if (cy_q == C_LAST) begin
            state_d = S_DONE;
          end else begin
            cx_d = '0;
            cy_d = cy_q + CW'(1);
          end
        end else begin
          cx_d = cx_q + CW'(1);
        end
      end

      S_DONE: begin
        last_grant_d = grant_q[2] ? 2'd2 : (grant_q[1] ? 2'd1 : 2'd0);
        grant_d      = 3'b000;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        grant_d = 3'b000;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register. last_grant resets to 2 so requester 0 wins first.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin : p_state
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 3'b000;
      last_grant_q <= 2'd2;
      base_x_q     <= 8'd0;
      base_y_q     <= 7'd0;
      colour_q     <= 3'd0;
      cx_q         <= '0;
      cy_q         <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      colour_q     <= colour_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Pixel coordinates wrap naturally in the 8/7-bit adders.
  // --------------------------------------------------------------------------
  assign bus.grant      = grant_q;
  assign bus.plot       = (state_q == S_PLOT);
  assign bus.done       = (state_q == S_DONE) ? grant_q : 3'b000;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.vga_x      = base_x_q + {{(8 - CW){1'b0}}, cx_q};
  assign bus.vga_y      = base_y_q + {{(7 - CW){1'b0}}, cy_q};
  assign bus.vga_colour = colour_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_draw_arbiter
//  Description : Self-checking bench for draw_arbiter. A transaction-level
//                model turns request patterns into an expected per-cycle
//                timeline of grant/done/plot/pixel values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_draw_arbiter;

  localparam int SIZE = 4;
  localparam int S2   = SIZE * SIZE;
  localparam int MAXC = 128;

  logic clk = 1'b0;
  logic reset;

  draw_arbiter_if bus ();

  draw_arbiter #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Per-requester stimulus
  logic [7:0] sx [3];
  logic [6:0] sy [3];
  logic [2:0] sc [3];

  // Timeline: req to drive in cycle c, expected and observed output words
  logic [2:0]  m_req [0:MAXC];
  logic [25:0] exp_w [0:MAXC];
  logic [25:0] obs_w [0:MAXC];

  // Model state persisting across scenarios
  int m_last;
  int m_hx, m_hy, m_hc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [25:0] pack_obs();
    return {bus.busy, bus.plot, bus.grant, bus.done,
            bus.vga_colour, bus.vga_y, bus.vga_x};
  endfunction

  function automatic string fmt(input logic [25:0] w);
    return $sformatf("busy=%b plot=%b grant=%b done=%b col=%b y=%0d x=%0d",
                     w[25], w[24], w[23:21], w[20:18], w[17:15], w[14:8], w[7:0]);
  endfunction

  task automatic drive_coords();
    bus.req_x      = {sx[2], sx[1], sx[0]};
    bus.req_y      = {sy[2], sy[1], sy[0]};
    bus.req_colour = {sc[2], sc[1], sc[0]};
  endtask

  task automatic model_reset();
    m_last = 2;
    m_hx   = 0;
    m_hy   = 0;
    m_hc   = 0;
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    bus.req = 3'b000;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  // Transaction-level model. A box granted at the end of idle cycle t plots
  // pixels in cycles t+1..t+S2, pulses done at t+S2+1 and the arbiter is idle
  // again at t+S2+2. Requests only matter in idle cycles.
  task automatic model_run(input logic [2:0] req_init, input int ev_cyc,
                           input logic [2:0] ev_val, input bit drop_on_done,
                           input int rel_cyc, input int n);
    logic [2:0] cur;
    logic [2:0] g;
    logic [2:0] d;
    int mode;      // 0 idle, 1 plotting, 2 done pulse
    int owner, p, bx, by, bc;
    bit found;
    cur = req_init;
    mode = 0; owner = 0; p = 0; bx = 0; by = 0; bc = 0;
    for (int c = 0; c <= n; c++) begin
      if (c == ev_cyc) cur = ev_val;
      if (rel_cyc >= 0 && c >= rel_cyc) cur = 3'b000;
      m_req[c] = cur;
      if (mode == 1) begin
        m_hx = (bx + p % SIZE) % 256;
        m_hy = (by + p / SIZE) % 128;
        m_hc = bc;
      end
      g = (mode != 0) ? 3'(1 << owner) : 3'b000;
      d = (mode == 2) ? 3'(1 << owner) : 3'b000;
      exp_w[c] = {(mode != 0), (mode == 1), g, d, 3'(m_hc), 7'(m_hy), 8'(m_hx)};
      if (mode == 0) begin
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
          int idx;
          idx = (m_last + k) % 3;
          if (!found && cur[idx]) begin
            found = 1'b1;
            owner = idx;
          end
        end
        if (found) begin
          bx = int'(sx[owner]); by = int'(sy[owner]); bc = int'(sc[owner]);
          p = 0;
          mode = 1;
        end
      end else if (mode == 1) begin
        if (p == S2 - 1) mode = 2;
        else p++;
      end else begin
        m_last = owner;
        mode = 0;
        if (drop_on_done) cur[owner] = 1'b0;
      end
    end
  endtask

  // Drives the model's request timeline and records outputs for cycles 1..n.
  task automatic capture(input int n);
    for (int c = 0; c <= n; c++) begin
      if (c > 0) begin
        tick();
        obs_w[c] = pack_obs();
      end
      bus.req = m_req[c];
      drive_coords();
    end
  endtask

  task automatic randomize_coords();
    for (int i = 0; i < 3; i++) begin
      sx[i] = 8'($urandom_range(0, 255));
      sy[i] = 7'($urandom_range(0, 127));
      sc[i] = 3'($urandom_range(0, 7));
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [25:0] w;
    reset   = 1'b1;
    bus.req = 3'b111;
    randomize_coords();
    drive_coords();
    for (int i = 0; i < 2; i++) begin
      tick();
      w = pack_obs();
      checks++;
      if (w !== 26'd0) begin
        errors++;
        $display("FAIL reset c%0d: got %s, expected all zero", i, fmt(w));
      end
    end
    reset   = 1'b0;
    bus.req = 3'b000;
    model_reset();
    tick();
    w = pack_obs();
    checks++;
    if (w !== 26'd0) begin
      errors++;
      $display("FAIL reset_idle: got %s, expected all zero", fmt(w));
    end
  endtask

  task automatic test_single_box();
    int n = S2 + 3;
    randomize_coords();
    sx[0] = 8'd10; sy[0] = 7'd20; sc[0] = 3'b100;
    model_run(3'b001, -1, 3'b000, 1'b1, -1, n);
    capture(n);
    for (int c = 1; c <= n; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        errors++;
        $display("FAIL single_box c%0d: got %s, expected %s", c, fmt(obs_w[c]), fmt(exp_w[c]));
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = 3 * (S2 + 2) + 2;
    apply_reset();
    randomize_coords();
    model_run(3'b111, -1, 3'b000, 1'b1, -1, n);
    capture(n);
    for (int c = 1; c <= n; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        errors++;
        $display("FAIL back_to_back c%0d: got %s, expected %s", c, fmt(obs_w[c]), fmt(exp_w[c]));
      end
    end
  endtask

  task automatic test_round_robin();
    int n = 40 + S2 + 4;
    randomize_coords();
    // requester 1 alone first, then 1 and 2 both held; released at cycle 40
    model_run(3'b010, 1, 3'b110, 1'b0, 40, n);
    capture(n);
    for (int c = 1; c <= n; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        errors++;
        $display("FAIL round_robin c%0d: got %s, expected %s", c, fmt(obs_w[c]), fmt(exp_w[c]));
      end
    end
  endtask

  task automatic test_wrap();
    int n = S2 + 3;
    randomize_coords();
    sx[0] = 8'd254; sy[0] = 7'd126;
    model_run(3'b001, -1, 3'b000, 1'b1, -1, n);
    capture(n);
    for (int c = 1; c <= n; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        errors++;
        $display("FAIL wrap c%0d: got %s, expected %s", c, fmt(obs_w[c]), fmt(exp_w[c]));
      end
    end
  endtask

  task automatic test_req_drop();
    int n = S2 + 3;
    randomize_coords();
    model_run(3'b001, 5, 3'b000, 1'b1, -1, n);
    capture(n);
    for (int c = 1; c <= n; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        errors++;
        $display("FAIL req_drop c%0d: got %s, expected %s", c, fmt(obs_w[c]), fmt(exp_w[c]));
      end
    end
  endtask

  task automatic test_reset_mid_plot();
    logic [25:0] w;
    int n;
    randomize_coords();
    model_run(3'b001, -1, 3'b000, 1'b1, -1, 7);
    capture(7);
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        errors++;
        $display("FAIL abort_pre c%0d: got %s, expected %s", c, fmt(obs_w[c]), fmt(exp_w[c]));
      end
    end
    reset = 1'b1;
    tick();
    w = pack_obs();
    checks++;
    if (w !== 26'd0) begin
      errors++;
      $display("FAIL abort_reset: got %s, expected all zero", fmt(w));
    end
    reset = 1'b0;
    model_reset();
    randomize_coords();
    n = S2 + 3;
    model_run(3'b001, -1, 3'b000, 1'b1, -1, n);
    capture(n);
    for (int c = 1; c <= n; c++) begin
      checks++;
      if (obs_w[c] !== exp_w[c]) begin
        errors++;
        $display("FAIL abort_restart c%0d: got %s, expected %s", c, fmt(obs_w[c]), fmt(exp_w[c]));
      end
    end
  endtask

  task automatic test_random();
    int n = 3 * (S2 + 2) + 2;
    for (int it = 0; it < 6; it++) begin
      randomize_coords();
      model_run(3'($urandom_range(1, 7)), -1, 3'b000, 1'b1, -1, n);
      capture(n);
      for (int c = 1; c <= n; c++) begin
        checks++;
        if (obs_w[c] !== exp_w[c]) begin
          errors++;
          $display("FAIL random%0d c%0d: got %s, expected %s", it, c, fmt(obs_w[c]), fmt(exp_w[c]));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      sx[i] = 8'd0; sy[i] = 7'd0; sc[i] = 3'd0;
    end
    drive_coords();
    model_reset();

    test_reset();
    test_single_box();
    test_back_to_back();
    test_round_robin();
    test_wrap();
    test_req_drop();
    test_reset_mid_plot();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
